// File: rtl/mips_mem_pkg.sv
// Shared data-memory definitions: bus widths, word addressing and the store-buffer entry payload.
package mips_mem_pkg;

    localparam int unsigned ADDR_W      = 32;
    localparam int unsigned DATA_W      = 32;
    localparam int unsigned WORD_OFFSET = 2;
    localparam int unsigned WADDR_W     = ADDR_W - WORD_OFFSET;

    typedef struct packed {
        logic [WADDR_W-1:0] addr;
        logic [DATA_W-1:0]  data;
        logic               valid;
    } sb_entry_t;

    function automatic logic [WADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] byte_addr);
        return WADDR_W'(byte_addr >> WORD_OFFSET);
    endfunction

    function automatic logic [ADDR_W-1:0] byte_addr(input logic [WADDR_W-1:0] waddr);
        return {waddr, {WORD_OFFSET{1'b0}}};
    endfunction

endpackage

// File: rtl/sb_fwd_match.sv
// Store-to-load forwarding: finds the youngest valid buffered store whose word address matches the load.
module sb_fwd_match
    import mips_mem_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  sb_entry_t          entries_i [DEPTH],
    input  logic [PTR_W-1:0]   tail_i,
    input  logic [WADDR_W-1:0] load_waddr_i,
    output logic               hit_o,
    output logic [DATA_W-1:0]  data_o
);

    logic [PTR_W-1:0] idx;

    // Walk oldest to youngest so the youngest match is the last one to assign.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        idx    = '0;
        for (int age = DEPTH; age > 0; age--) begin
            idx = tail_i - PTR_W'(age);
            if (entries_i[idx].valid && (entries_i[idx].addr == load_waddr_i)) begin
                hit_o  = 1'b1;
                data_o = entries_i[idx].data;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Posted-write FIFO between the memory stage and data memory, with load forwarding and a shared memory port.
module store_buffer
    import mips_mem_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_mem_read,
    input  logic              core_mem_write,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              stall,
    output logic              empty,
    input  logic              mem_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    sb_entry_t          entries_q [DEPTH];
    sb_entry_t          entries_d [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [WADDR_W-1:0] core_waddr;
    logic               fwd_hit;
    logic [DATA_W-1:0]  fwd_data;
    logic               load_hit;
    logic               load_miss;
    logic               full;
    logic               drain;
    logic               push;
    sb_entry_t          head_entry;

    assign core_waddr = word_addr(core_addr);
    assign head_entry = entries_q[head_q];

    sb_fwd_match #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fwd_match (
        .entries_i    (entries_q),
        .tail_i       (tail_q),
        .load_waddr_i (core_waddr),
        .hit_o        (fwd_hit),
        .data_o       (fwd_data)
    );

    // A load miss owns the memory port; drains and pushes only proceed around it.
    always_comb begin
        full      = (count_q == CNT_W'(DEPTH));
        load_hit  = core_mem_read && fwd_hit;
        load_miss = core_mem_read && !fwd_hit;
        drain     = mem_ready && (count_q != '0) && !load_miss;
        push      = core_mem_write && !core_mem_read && (!full || drain);
        stall     = (load_miss && !mem_ready)
                  || (core_mem_write && core_mem_read)
                  || (core_mem_write && !core_mem_read && !push);
        empty     = (count_q == '0);
    end

    // Memory port mux and load data return.
    always_comb begin
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = core_addr;
        mem_wdata  = '0;
        core_rdata = load_hit ? fwd_data : mem_rdata;
        if (load_miss) begin
            mem_read = 1'b1;
        end else if (drain) begin
            mem_write = 1'b1;
            mem_addr  = byte_addr(head_entry.addr);
            mem_wdata = head_entry.data;
        end
    end

    // Pop is applied before push so a full buffer can recycle the head slot in one cycle.
    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        if (drain) begin
            entries_d[head_q].valid = 1'b0;
            head_d                  = head_q + PTR_W'(1);
        end
        if (push) begin
            entries_d[tail_q] = '{addr: core_waddr, data: core_wdata, valid: 1'b1};
            tail_d            = tail_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(drain);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            entries_q <= entries_d;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed scenarios plus random traffic against a queue-based reference model.
module tb_store_buffer;
    import mips_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_mem_read, core_mem_write, mem_ready;
    logic [31:0] core_addr, core_wdata, core_rdata;
    logic        stall, empty, mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .core_mem_read  (core_mem_read),
        .core_mem_write (core_mem_write),
        .core_addr      (core_addr),
        .core_wdata     (core_wdata),
        .core_rdata     (core_rdata),
        .stall          (stall),
        .empty          (empty),
        .mem_ready      (mem_ready),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata)
    );

    // Environment data memory: 64 words, cleared on the same reset.
    logic [31:0] dmem [64];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) dmem[i] <= '0;
        end else if (mem_write) begin
            dmem[mem_addr[7:2]] <= mem_wdata;
        end
    end
    assign mem_rdata = dmem[mem_addr[7:2]];

    typedef struct {
        logic [29:0] w;
        logic [31:0] d;
    } ent_t;

    ent_t        q[$];
    logic [31:0] ref_mem [64];
    logic        m_drain, m_push;
    ent_t        m_entry;
    int          n_assert = 0;
    int          n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs, then check every output against the reference model.
    task automatic cyc(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic rdy);
        int   hit_idx;
        logic hit, miss, e_stall;
        core_mem_read  = rd;
        core_mem_write = wr;
        core_addr      = a;
        core_wdata     = d;
        mem_ready      = rdy;
        #1;
        hit_idx = -1;
        foreach (q[i]) if (q[i].w == 30'(a >> 2)) hit_idx = i;
        hit     = rd && (hit_idx >= 0);
        miss    = rd && !hit;
        m_drain = rdy && (q.size() != 0) && !miss;
        m_push  = wr && !rd && ((q.size() < 4) || m_drain);
        e_stall = (miss && !rdy) || (wr && rd) || (wr && !rd && !m_push);
        m_entry = '{w: 30'(a >> 2), d: d};
        chk("empty", 32'(empty), 32'(q.size() == 0));
        chk("stall", 32'(stall), 32'(e_stall));
        chk("mem_read", 32'(mem_read), 32'(miss));
        chk("mem_write", 32'(mem_write), 32'(m_drain));
        if (m_drain) begin
            chk("mem_addr_drain", mem_addr, {q[0].w, 2'b00});
            chk("mem_wdata_drain", mem_wdata, q[0].d);
        end else begin
            chk("mem_addr_idle", mem_addr, a);
            chk("mem_wdata_idle", mem_wdata, 32'h0);
        end
        if (rd && !e_stall) begin
            if (hit) chk("rdata_fwd", core_rdata, q[hit_idx].d);
            else     chk("rdata_mem", core_rdata, ref_mem[a[7:2]]);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        if (m_drain) begin
            ref_mem[q[0].w[5:0]] = q[0].d;
            void'(q.pop_front());
        end
        if (m_push) q.push_back(m_entry);
        @(negedge clk);
    endtask

    task automatic step(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic rdy);
        cyc(rd, wr, a, d, rdy);
        adv();
    endtask

    task automatic do_reset();
        core_mem_read  = 1'b0;
        core_mem_write = 1'b0;
        core_addr      = '0;
        core_wdata     = '0;
        rst            = 1'b1;
        #1;
        chk("rst_empty", 32'(empty), 32'h1);
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_mem_write", 32'(mem_write), 32'h0);
        chk("rst_mem_read", 32'(mem_read), 32'h0);
        q.delete();
        for (int i = 0; i < 64; i++) ref_mem[i] = '0;
        m_drain = 1'b0;
        m_push  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic rd, wr;
        rst            = 1'b1;
        core_mem_read  = 1'b0;
        core_mem_write = 1'b0;
        core_addr      = '0;
        core_wdata     = '0;
        mem_ready      = 1'b0;
        @(negedge clk);
        do_reset();

        // Reset mid-run with three entries buffered; the port would be draining.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'h70 + 32'(4 * i), 32'hC0 + 32'(i), 1'b0);
        mem_ready = 1'b1;
        do_reset();
        cyc(1'b1, 1'b0, 32'h74, 32'h0, 1'b1);
        chk("post_rst_load", core_rdata, 32'h0);
        adv();

        // Single store drains the following cycle.
        step(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b1);
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        chk("t2_mem_write", 32'(mem_write), 32'h1);
        chk("t2_mem_addr", mem_addr, 32'h10);
        chk("t2_mem_wdata", mem_wdata, 32'hDEADBEEF);
        adv();
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        chk("t2_empty", 32'(empty), 32'h1);
        adv();

        // Forwarding on word index, byte offset ignored.
        step(1'b0, 1'b1, 32'h20, 32'h11, 1'b0);
        cyc(1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
        chk("t3_rdata", core_rdata, 32'h11);
        chk("t3_stall", 32'(stall), 32'h0);
        chk("t3_mem_read", 32'(mem_read), 32'h0);
        adv();
        cyc(1'b1, 1'b0, 32'h23, 32'h0, 1'b0);
        chk("t3_rdata_off", core_rdata, 32'h11);
        adv();

        // Duplicate address: youngest forwarded, both drain in order.
        step(1'b0, 1'b1, 32'h30, 32'hA, 1'b0);
        step(1'b0, 1'b1, 32'h30, 32'hB, 1'b0);
        cyc(1'b1, 1'b0, 32'h30, 32'h0, 1'b0);
        chk("t4_rdata_young", core_rdata, 32'hB);
        adv();
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        chk("t4_drain0", mem_addr, 32'h20);
        adv();
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        chk("t4_drainA", mem_wdata, 32'hA);
        adv();
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        chk("t4_drainB", mem_wdata, 32'hB);
        adv();
        cyc(1'b1, 1'b0, 32'h30, 32'h0, 1'b1);
        chk("t4_mem_final", core_rdata, 32'hB);
        adv();

        // Full buffer: stall until a drain frees a slot, then push+pop.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'h50 + 32'(4 * i), 32'h100 + 32'(i), 1'b0);
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, 1'b1, 32'h60, 32'h104, 1'b0);
            chk("t5_full_stall", 32'(stall), 32'h1);
            chk("t5_not_empty", 32'(empty), 32'h0);
            adv();
        end
        cyc(1'b0, 1'b1, 32'h60, 32'h104, 1'b1);
        chk("t5_pushpop_stall", 32'(stall), 32'h0);
        chk("t5_pushpop_addr", mem_addr, 32'h50);
        adv();
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
            chk("t5_fifo_order", mem_wdata, 32'h101 + 32'(i));
            adv();
        end
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        chk("t5_drained", 32'(empty), 32'h1);
        adv();

        // Load miss owns the port: no drain, stall until ready.
        step(1'b0, 1'b1, 32'h18, 32'h77, 1'b0);
        cyc(1'b1, 1'b0, 32'h40, 32'h0, 1'b0);
        chk("t6_stall", 32'(stall), 32'h1);
        chk("t6_mem_read", 32'(mem_read), 32'h1);
        chk("t6_no_drain", 32'(mem_write), 32'h0);
        adv();
        cyc(1'b1, 1'b0, 32'h40, 32'h0, 1'b1);
        chk("t6_unstall", 32'(stall), 32'h0);
        chk("t6_no_drain_ready", 32'(mem_write), 32'h0);
        chk("t6_rdata", core_rdata, 32'h0);
        adv();
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

        // Random traffic over a small address window to provoke hits and duplicates.
        for (int n = 0; n < 600; n++) begin
            int unsigned r;
            r  = $urandom_range(0, 99);
            rd = (r < 35) || (r >= 95);
            wr = (r >= 35 && r < 80) || (r >= 95);
            step(rd, wr, 32'($urandom_range(0, 11) * 4 + $urandom_range(0, 3)),
                 $urandom, 1'($urandom_range(0, 9) < 6));
        end
        for (int n = 0; n < 6; n++) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        chk("final_empty", 32'(empty), 32'h1);
        adv();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
